// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolver.
// Drives a registered redirect/flush handshake to fetch.
module branch_resolve #(
  parameter int ADDR_W       = 12,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [16:0]       imm,
  input  logic [26:0]       target,
  input  logic [31:0]       rs_data,
  input  logic              rstatus_nz,
  input  logic              BrNEq,
  input  logic              BrLT,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              link_we,
  output logic [31:0]       link_data,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  localparam int CW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LOAD =
    CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 1);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BEX = 5'b10110;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_in_ready;
  logic              r_rv;
  logic [ADDR_W-1:0] r_rpc;
  logic              r_flush;
  logic              r_link_we;
  logic [31:0]       r_link_data;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_accept;
  logic [ADDR_W+16:0] w_imm_ext;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_abs_tgt;
  logic [ADDR_W-1:0] w_jr_tgt;
  logic              w_taken;
  logic              w_is_jal;
  logic [ADDR_W-1:0] w_tgt;
  logic [1:0]        w_next;
  logic [CW-1:0]     w_cnt_next;
  logic              w_unused;

  assign w_accept  = in_valid & r_in_ready;
  assign w_imm_ext = {{ADDR_W{imm[16]}}, imm};
  assign w_pc_inc  = pc_in + A_ONE;
  assign w_br_tgt  = w_pc_inc + w_imm_ext[ADDR_W-1:0];
  assign w_abs_tgt = target[ADDR_W-1:0];
  assign w_jr_tgt  = rs_data[ADDR_W-1:0];
  assign w_unused  = ^{w_imm_ext[ADDR_W+16:ADDR_W],
                       target[26:ADDR_W],
                       rs_data[31:ADDR_W]};

  // Opcode decode: taken condition and target select
  always_comb begin
    w_taken  = 1'b0;
    w_is_jal = 1'b0;
    w_tgt    = w_br_tgt;
    unique case (1'b1)
      (opcode == OP_BNE): begin
        w_taken = BrNEq;
        w_tgt   = w_br_tgt;
      end
      (opcode == OP_BLT): begin
        w_taken = BrLT;
        w_tgt   = w_br_tgt;
      end
      (opcode == OP_J): begin
        w_taken = 1'b1;
        w_tgt   = w_abs_tgt;
      end
      (opcode == OP_JAL): begin
        w_taken  = 1'b1;
        w_is_jal = 1'b1;
        w_tgt    = w_abs_tgt;
      end
      (opcode == OP_JR): begin
        w_taken = 1'b1;
        w_tgt   = w_jr_tgt;
      end
      (opcode == OP_BEX): begin
        w_taken = rstatus_nz;
        w_tgt   = w_abs_tgt;
      end
      default: begin
        w_taken = 1'b0;
      end
    endcase
  end

  // Next-state and flush counter logic
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_taken) begin
          w_next = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 1) begin
            w_next = S_IDLE;
          end else begin
            w_next     = S_FLUSH;
            w_cnt_next = C_LOAD;
          end
        end
      end
      S_FLUSH: begin
        if (r_cnt == C_ONE) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - C_ONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; handshake outputs registered off next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_rv       <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_next == S_IDLE);
      r_rv       <= (w_next == S_REDIRECT);
      r_flush    <= (w_next != S_IDLE);
    end
  end

  // Latch target and bump saturating count on taken accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rpc       <= '0;
      r_taken_cnt <= '0;
    end else if (w_accept && w_taken) begin
      r_rpc <= w_tgt;
      if (r_taken_cnt != '1) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  // jal link write: one-cycle pulse, data held until next jal
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_link_we   <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_we <= w_accept & w_is_jal;
      if (w_accept && w_is_jal) begin
        r_link_data <= {{(32-ADDR_W){1'b0}}, w_pc_inc};
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign redirect_valid = r_rv;
  assign redirect_pc    = r_rpc;
  assign flush          = r_flush;
  assign link_we        = r_link_we;
  assign link_data      = r_link_data;
  assign taken_count    = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve.
// Vector table plus hand-written multi-cycle sequences.
module tb_branch_resolve;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [11:0] pc_in;
  logic [16:0] imm;
  logic [26:0] target;
  logic [31:0] rs_data;
  logic        rstatus_nz;
  logic        BrNEq;
  logic        BrLT;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [11:0] redirect_pc;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic [15:0] taken_count;

  int checks = 0;
  int errors = 0;

  branch_resolve #(
    .ADDR_W(12), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .pc_in(pc_in), .imm(imm),
    .target(target), .rs_data(rs_data),
    .rstatus_nz(rstatus_nz),
    .BrNEq(BrNEq), .BrLT(BrLT),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .link_we(link_we), .link_data(link_data),
    .taken_count(taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  op;
    logic [11:0] pc;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic [31:0] rs;
    logic        rnz;
    logic        neq;
    logic        lt;
    logic        exp_taken;
    logic [11:0] exp_pc;
    logic        exp_link;
    logic [31:0] exp_ldata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op,
                       input logic [11:0] pc,
                       input logic [16:0] im,
                       input logic [26:0] tg,
                       input logic [31:0] rs,
                       input logic rnz,
                       input logic neq,
                       input logic lt);
    opcode     = op;
    pc_in      = pc;
    imm        = im;
    target     = tg;
    rs_data    = rs;
    rstatus_nz = rnz;
    BrNEq      = neq;
    BrLT       = lt;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for in_ready", nm);
    end
  endtask

  initial begin
    vecs[0] = '{5'b00010, 12'h010, 17'h1FFFD, 27'h0, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b1, 12'h00E, 1'b0, 32'h0};
    vecs[1] = '{5'b00010, 12'h100, 17'h00010, 27'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 32'h0};
    vecs[2] = '{5'b00110, 12'hFFF, 17'h00005, 27'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 32'h0};
    vecs[3] = '{5'b00110, 12'h200, 17'h00005, 27'h0, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0};
    vecs[4] = '{5'b00001, 12'h300, 17'h0, 27'h1234567, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 12'h567, 1'b0, 32'h0};
    vecs[5] = '{5'b00100, 12'h300, 17'h0, 27'h0, 32'hABCD5678,
                1'b0, 1'b0, 1'b0, 1'b1, 12'h678, 1'b0, 32'h0};
    vecs[6] = '{5'b10110, 12'h300, 17'h0, 27'h0000ABC, 32'h0,
                1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 32'h0};
    vecs[7] = '{5'b10110, 12'h300, 17'h0, 27'h0000FFF, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0, 32'h0};
    vecs[8] = '{5'b00000, 12'h300, 17'h1, 27'h0000111, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 32'h0};
    vecs[9] = '{5'b00011, 12'hFFF, 17'h0, 27'h0000ABC, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 1'b1, 32'h0};

    reset          = 1'b0;
    in_valid       = 1'b0;
    redirect_ready = 1'b0;
    drive(5'b0, 12'h0, 17'h0, 27'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_rpc", {20'b0, redirect_pc}, 32'd0);
    chk("rst_link_we", {31'b0, link_we}, 32'd0);
    chk("rst_link_data", link_data, 32'd0);
    chk("rst_count", {16'b0, taken_count}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    // bne taken, ready held high: minimum redirect path
    redirect_ready = 1'b1;
    drive(5'b00010, 12'h010, 17'h1FFFD, 27'h0, 32'h0,
          1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("bne_rv", {31'b0, redirect_valid}, 32'd1);
    chk("bne_rpc", {20'b0, redirect_pc}, 32'h00E);
    chk("bne_flush1", {31'b0, flush}, 32'd1);
    chk("bne_ready0", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    chk("bne_rv_drop", {31'b0, redirect_valid}, 32'd0);
    chk("bne_flush2", {31'b0, flush}, 32'd1);
    @(negedge clock);
    chk("bne_flush_end", {31'b0, flush}, 32'd0);
    chk("bne_idle", {31'b0, in_ready}, 32'd1);
    chk("bne_count", {16'b0, taken_count}, 32'd1);

    // vector table
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].op, vecs[v].pc, vecs[v].imm,
            vecs[v].tgt, vecs[v].rs, vecs[v].rnz,
            vecs[v].neq, vecs[v].lt);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk($sformatf("v%0d_rv", v),
          {31'b0, redirect_valid}, {31'b0, vecs[v].exp_taken});
      chk($sformatf("v%0d_flush", v),
          {31'b0, flush}, {31'b0, vecs[v].exp_taken});
      chk($sformatf("v%0d_link_we", v),
          {31'b0, link_we}, {31'b0, vecs[v].exp_link});
      if (vecs[v].exp_taken)
        chk($sformatf("v%0d_rpc", v),
            {20'b0, redirect_pc}, {20'b0, vecs[v].exp_pc});
      if (vecs[v].exp_link)
        chk($sformatf("v%0d_link_data", v),
            link_data, vecs[v].exp_ldata);
      wait_idle($sformatf("v%0d_idle", v));
    end
    chk("table_count", {16'b0, taken_count}, 32'd7);

    // three back-to-back not-taken blt
    drive(5'b00110, 12'h040, 17'h00003, 27'h0, 32'h0,
          1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_in = 12'h040 + 12'(k);
      @(negedge clock);
      chk($sformatf("nt%0d_ready", k),
          {31'b0, in_ready}, 32'd1);
      chk($sformatf("nt%0d_rv_fl", k),
          {30'b0, redirect_valid, flush}, 32'd0);
    end
    in_valid = 1'b0;
    chk("nt_count", {16'b0, taken_count}, 32'd7);

    // jal with redirect_ready delayed
    redirect_ready = 1'b0;
    drive(5'b00011, 12'h020, 17'h0, 27'h0000123, 32'h0,
          1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        in_valid = 1'b0;
        chk("jal_link_we", {31'b0, link_we}, 32'd1);
        chk("jal_link_data", link_data, 32'h00000021);
      end else begin
        chk($sformatf("jal_link_we_off%0d", i),
            {31'b0, link_we}, 32'd0);
      end
      chk($sformatf("jal_rv%0d", i),
          {31'b0, redirect_valid}, 32'd1);
      chk($sformatf("jal_rpc%0d", i),
          {20'b0, redirect_pc}, 32'h123);
      chk($sformatf("jal_busy%0d", i),
          {31'b0, in_ready}, 32'd0);
      if (i == 3) redirect_ready = 1'b1;
    end
    @(negedge clock);
    chk("jal_rv_drop", {31'b0, redirect_valid}, 32'd0);
    chk("jal_flush", {31'b0, flush}, 32'd1);
    chk("jal_busy_fl", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    chk("jal_idle", {31'b0, in_ready}, 32'd1);
    chk("jal_flush_end", {31'b0, flush}, 32'd0);
    chk("jal_ldata_hold", link_data, 32'h00000021);
    chk("jal_count", {16'b0, taken_count}, 32'd8);

    // reset in second REDIRECT cycle
    redirect_ready = 1'b0;
    drive(5'b00010, 12'h010, 17'h00004, 27'h0, 32'h0,
          1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("ra_rv1", {31'b0, redirect_valid}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("ra_rv", {31'b0, redirect_valid}, 32'd0);
    chk("ra_flush", {31'b0, flush}, 32'd0);
    chk("ra_count", {16'b0, taken_count}, 32'd0);
    chk("ra_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    redirect_ready = 1'b1;
    @(negedge clock);
    chk("ra_post_ready", {31'b0, in_ready}, 32'd1);
    chk("ra_post_rv", {31'b0, redirect_valid}, 32'd0);
    drive(5'b00010, 12'h010, 17'h1FFFD, 27'h0, 32'h0,
          1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("ra_bne_rv", {31'b0, redirect_valid}, 32'd1);
    chk("ra_bne_rpc", {20'b0, redirect_pc}, 32'h00E);
    chk("ra_bne_count", {16'b0, taken_count}, 32'd1);
    wait_idle("ra_bne_idle");
    chk("ra_bne_flush_end", {31'b0, flush}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer end of the branch-compare interface: takes the BrNEq/BrLT flags produced for the execute-stage instruction.
- Decides whether the instruction (bne, blt, j, jal, jr, bex) redirects control flow, computes the target PC, and drives a registered redirect/flush handshake to fetch.
- Sits in the execute stage, between the comparator/decoder and the PC register.
- Also produces the jal link write and a taken-branch counter.

Parameters:
ADDR_W, 12, PC / instruction-address width (4096-word imem)
FLUSH_CYCLES, 2, cycles flush stays high after redirect acceptance (>=1)
CNT_W, 16, width of taken-branch counter

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  execute-stage instruction valid
in_ready  output  1  block can accept an instruction (high only in IDLE)
opcode  input  5  instruction opcode[31:27]
pc_in  input  ADDR_W  PC of the instruction
imm  input  17  immediate N[16:0], two's complement
target  input  27  jump target T[26:0]
rs_data  input  32  register value for jr
rstatus_nz  input  1  rstatus != 0 (bex condition)
BrNEq  input  1  comparator: A != B
BrLT  input  1  comparator: A < B, signed (A = $rd, B = $rs)
redirect_valid  output  1  redirect_pc is valid
redirect_ready  input  1  fetch accepts the redirect
redirect_pc  output  ADDR_W  new PC
flush  output  1  squash younger pipeline stages
link_we  output  1  one-cycle write of r31
link_data  output  32  pc_in+1, zero-extended
taken_count  output  CNT_W  saturating count of taken redirects

Behaviour:
- Reset (reset low, async):
  - state=IDLE.
  - redirect_valid, redirect_pc, flush, link_we, link_data, taken_count = 0.
  - in_ready = 0 while reset is held, 1 in IDLE afterwards.
  - Reset mid-REDIRECT or mid-FLUSH abandons the operation immediately; no redirect is completed.
- Accept: in_valid & in_ready on a rising edge. in_valid while in_ready=0 is ignored; the producer holds the instruction.
- Decode at accept:
  - 00010 bne: taken = BrNEq; tgt = pc_in + 1 + sext(imm).
  - 00110 blt: taken = BrLT; tgt = pc_in + 1 + sext(imm).
  - 00001 j: always taken; tgt = target[ADDR_W-1:0].
  - 00011 jal: always taken; tgt = target[ADDR_W-1:0].
  - 00100 jr: always taken; tgt = rs_data[ADDR_W-1:0].
  - 10110 bex: taken = rstatus_nz; tgt = target[ADDR_W-1:0].
  - Any other opcode: not taken, no side effects.
- Arithmetic: target addition is modulo 2^ADDR_W (wrap-around, no error). sext extends imm bit 16.
- jal link:
  - link_we pulses high for exactly 1 cycle, the cycle after accept.
  - link_data = {zeros, pc_in+1 mod 2^ADDR_W}, held until the next jal.
- FSM:
  - IDLE: in_ready=1. On accept with taken=1: latch tgt into redirect_pc, increment taken_count (saturates at all-ones), and go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: redirect_valid=1, flush=1, redirect_pc stable. Wait for redirect_ready. When redirect_ready=1 (the handshake cycle): if FLUSH_CYCLES==1 go to IDLE, else load cnt=FLUSH_CYCLES-1 and go to FLUSH. redirect_valid deasserts the cycle after the handshake.
  - FLUSH: flush=1, redirect_valid=0. cnt decrements each cycle; leave to IDLE in the cycle where cnt==1.
- Timing:
  - Latency from accept to redirect_valid = 1 cycle. All outputs are registered.
  - redirect_ready high in the first REDIRECT cycle gives the minimum path: redirect_valid high for exactly 1 cycle, flush high for FLUSH_CYCLES+... total cycles = 1 + (FLUSH_CYCLES-1) = FLUSH_CYCLES.
  - redirect_ready outside REDIRECT is ignored.
- Not-taken branches: no flush, no redirect; in_ready stays 1, so back-to-back accepts are allowed every cycle.

Test Plan:
- bne: pc_in=0x010, imm=17'h1FFFD, BrNEq=1 -> 1 cycle later redirect_valid=1, redirect_pc=0x00E, flush=1. redirect_ready held high -> flush high for 2 cycles total, taken_count=1.
- blt not taken: pc_in=0x040, BrLT=0, 3 back-to-back instructions -> in_ready stays 1, redirect_valid and flush never assert, taken_count unchanged.
- blt wrap: pc_in=0xFFF, imm=5, BrLT=1 -> redirect_pc=0x005.
- jal: pc_in=0x020, target=0x123, redirect_ready delayed 3 cycles -> link_we pulses once with link_data=0x00000021; redirect_valid held 4 cycles with redirect_pc=0x123; in_ready=0 until return to IDLE.
- jr with rs_data=0xABCD5678 -> redirect_pc=0x678. bex with rstatus_nz=0 -> no redirect.
- Reset asserted in the 2nd REDIRECT cycle -> redirect_valid, flush, and taken_count=0 immediately. After release, in_ready=1 and the next bne resolves normally.
